bus_arbiter2: RTL and testbench

- Two-master bus arbiter that owns the select of the shared 32-bit address/data bus muxes.
- Produces a registered 2-bit grant whose encoding drives the 3-input bus mux select directly:
  - 2'b10 selects master 0.
  - 2'b01 selects master 1.
  - 2'b00 parks the bus at zero.
- Round-robin between simultaneous requesters.
- Bounded hold time so one master cannot starve the other.

---
 rtl/bus_arbiter2_pkg.sv | 28 ++
 rtl/bus_arbiter2_hold_counter.sv | 32 +++
 rtl/bus_arbiter2.sv | 101 ++++++++++
 tb/tb_bus_arbiter2.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/bus_arbiter2_pkg.sv
// Shared grant encodings, FSM states and owner tags for the two-master bus arbiter.
// The grant encodings feed the 3-input bus mux select directly.
package bus_arbiter2_pkg;

    localparam logic [1:0] GRANT_NONE = 2'b00;
    localparam logic [1:0] GRANT_M0   = 2'b10;
    localparam logic [1:0] GRANT_M1   = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWNER_M0 = 1'b0,
        OWNER_M1 = 1'b1
    } owner_e;

    function automatic logic [1:0] state_grant(input arb_state_e s);
        case (s)
            ST_OWN0: state_grant = GRANT_M0;
            ST_OWN1: state_grant = GRANT_M1;
            default: state_grant = GRANT_NONE;
        endcase
    endfunction

endpackage

// File: rtl/bus_arbiter2_hold_counter.sv
// Saturating hold counter: counts contended cycles of the current bus owner.
// Stops at MAX_HOLD-1 and flags expiry there; never wraps.
module arb_hold_counter #(
    parameter int unsigned MAX_HOLD = 16,
    parameter int unsigned CW       = 5
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          clr,
    input  logic          inc,
    output logic [CW-1:0] cnt,
    output logic          expired
);

    localparam logic [CW-1:0] LIMIT = CW'(MAX_HOLD - 1);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (inc && (cnt_q != LIMIT)) begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    assign cnt     = cnt_q;
    assign expired = (cnt_q == LIMIT);

endmodule

// File: rtl/bus_arbiter2.sv
// Two-master round-robin bus arbiter with bounded hold time.
// Grant, preempt and hold_cnt are all registered; no combinational path from requests.
module bus_arbiter2
    import bus_arbiter2_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 16,
    parameter int unsigned CW       = 5
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          m0_req,
    input  logic          m1_req,
    output logic [1:0]    grant,
    output logic          m0_grant,
    output logic          m1_grant,
    output logic          preempt,
    output logic [CW-1:0] hold_cnt
);

    arb_state_e state_q, state_d;
    owner_e     last_q, last_d;
    logic [1:0] grant_q;
    logic       preempt_q, preempt_d;
    logic       cnt_clr, cnt_inc, expired;

    always_comb begin
        state_d   = state_q;
        preempt_d = 1'b0;
        last_d    = last_q;
        case (state_q)
            ST_IDLE: begin
                if (m0_req && m1_req) begin
                    state_d = (last_q == OWNER_M1) ? ST_OWN0 : ST_OWN1;
                end else if (m0_req) begin
                    state_d = ST_OWN0;
                end else if (m1_req) begin
                    state_d = ST_OWN1;
                end
            end
            ST_OWN0: begin
                if (!m0_req) begin
                    state_d = m1_req ? ST_OWN1 : ST_IDLE;
                end else if (m1_req && expired) begin
                    state_d   = ST_OWN1;
                    preempt_d = 1'b1;
                end
            end
            ST_OWN1: begin
                if (!m1_req) begin
                    state_d = m0_req ? ST_OWN0 : ST_IDLE;
                end else if (m0_req && expired) begin
                    state_d   = ST_OWN0;
                    preempt_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (state_d == ST_OWN0 && state_q != ST_OWN0) begin
            last_d = OWNER_M0;
        end else if (state_d == ST_OWN1 && state_q != ST_OWN1) begin
            last_d = OWNER_M1;
        end
    end

    // Counter restarts on any state change; otherwise it advances only while contended.
    assign cnt_clr = (state_d != state_q);
    assign cnt_inc = ((state_q == ST_OWN0) && m1_req) || ((state_q == ST_OWN1) && m0_req);

    arb_hold_counter #(
        .MAX_HOLD (MAX_HOLD),
        .CW       (CW)
    ) u_hold (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (cnt_clr),
        .inc     (cnt_inc),
        .cnt     (hold_cnt),
        .expired (expired)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            last_q    <= OWNER_M1;
            grant_q   <= GRANT_NONE;
            preempt_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            grant_q   <= state_grant(state_d);
            preempt_q <= preempt_d;
        end
    end

    assign grant    = grant_q;
    assign m0_grant = grant_q[1];
    assign m1_grant = grant_q[0];
    assign preempt  = preempt_q;

endmodule

// File: tb/tb_bus_arbiter2.sv
// Scoreboard bench for bus_arbiter2 (MAX_HOLD=4): directed vectors with hand-computed
// expectations, async reset check, then random requests checked against invariants.
module tb_bus_arbiter2;
    import bus_arbiter2_pkg::*;

    localparam int unsigned MAX_HOLD = 4;
    localparam int unsigned CW       = 2;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          m0_req, m1_req;
    logic [1:0]    grant;
    logic          m0_grant, m1_grant, preempt;
    logic [CW-1:0] hold_cnt;

    typedef struct packed {
        logic [1:0]    g;
        logic          p;
        logic [CW-1:0] c;
    } exp_t;

    exp_t expq[$];
    int   checks  = 0;
    int   errors  = 0;
    bit   rand_on = 1'b0;

    bus_arbiter2 #(
        .MAX_HOLD (MAX_HOLD),
        .CW       (CW)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .m0_req   (m0_req),
        .m1_req   (m1_req),
        .grant    (grant),
        .m0_grant (m0_grant),
        .m1_grant (m1_grant),
        .preempt  (preempt),
        .hold_cnt (hold_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    // Inputs change on the falling edge; the expectation applies after the next rising edge.
    task automatic drive(input logic r0, input logic r1, input logic [1:0] g,
                         input logic p, input int c);
        exp_t e;
        @(negedge clk);
        m0_req = r0;
        m1_req = r1;
        e.g = g;
        e.p = p;
        e.c = CW'(c);
        expq.push_back(e);
    endtask

    task automatic drain();
        int n = 0;
        while (expq.size() != 0 && n < 10) begin
            @(posedge clk);
            #2;
            n++;
        end
        if (expq.size() != 0) begin
            chk("scoreboard_drain_timeout", expq.size(), 0);
            expq.delete();
        end
    endtask

    // Directed monitor: pops one expectation per cycle once the DUT has updated.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (expq.size() != 0) begin
                e = expq.pop_front();
                chk("grant",    int'(grant),    int'(e.g));
                chk("preempt",  int'(preempt),  int'(e.p));
                chk("hold_cnt", int'(hold_cnt), int'(e.c));
                chk("m0_grant", int'(m0_grant), int'(e.g[1]));
                chk("m1_grant", int'(m1_grant), int'(e.g[0]));
            end
        end
    end

    // Random-phase monitor: invariant and starvation-bound checks.
    initial begin
        logic s0, s1;
        int   w0 = 0, w1 = 0;
        forever begin
            @(posedge clk);
            s0 = m0_req;
            s1 = m1_req;
            #1;
            if (rand_on) begin
                chk("grant_legal", int'(grant != 2'b11), 1);
                if (grant[1]) chk("grant_m0_requested", int'(s0), 1);
                if (grant[0]) chk("grant_m1_requested", int'(s1), 1);
                w0 = (s0 && !grant[1]) ? w0 + 1 : 0;
                w1 = (s1 && !grant[0]) ? w1 + 1 : 0;
                chk("m0_wait_bound", int'(w0 <= int'(MAX_HOLD) + 1), 1);
                chk("m1_wait_bound", int'(w1 <= int'(MAX_HOLD) + 1), 1);
            end else begin
                w0 = 0;
                w1 = 0;
            end
        end
    end

    initial begin
        reset_n = 1'b0;
        m0_req  = 1'b0;
        m1_req  = 1'b0;
        #1;
        chk("reset_grant",    int'(grant),    0);
        chk("reset_preempt",  int'(preempt),  0);
        chk("reset_hold_cnt", int'(hold_cnt), 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        // Idle for 5 cycles
        repeat (5) drive(0, 0, GRANT_NONE, 0, 0);
        // Round-robin from reset: M0 first, then M1
        drive(1, 1, GRANT_M0,   0, 0);
        drive(0, 0, GRANT_NONE, 0, 0);
        drive(1, 1, GRANT_M1,   0, 0);
        drive(0, 0, GRANT_NONE, 0, 0);
        // Single-cycle request from M0
        drive(1, 0, GRANT_M0,   0, 0);
        drive(0, 0, GRANT_NONE, 0, 0);
        // M0 owns, M1 contends until hold expiry, then back again
        drive(1, 0, GRANT_M0,   0, 0);
        drive(1, 1, GRANT_M0,   0, 1);
        drive(1, 1, GRANT_M0,   0, 2);
        drive(1, 1, GRANT_M0,   0, 3);
        drive(1, 1, GRANT_M1,   1, 0);
        drive(1, 1, GRANT_M1,   0, 1);
        drive(1, 1, GRANT_M1,   0, 2);
        drive(1, 1, GRANT_M1,   0, 3);
        drive(1, 1, GRANT_M0,   1, 0);
        drive(1, 1, GRANT_M0,   0, 1);
        // Counter holds while the other master is idle
        drive(1, 0, GRANT_M0,   0, 1);
        drive(1, 1, GRANT_M0,   0, 2);
        drive(1, 1, GRANT_M0,   0, 3);
        // Owner drops at the threshold: normal handoff, no preempt
        drive(0, 1, GRANT_M1,   0, 0);
        drive(0, 1, GRANT_M1,   0, 0);
        drive(0, 0, GRANT_NONE, 0, 0);
        // Direct handoffs without an idle bubble
        drive(0, 1, GRANT_M1,   0, 0);
        drive(1, 0, GRANT_M0,   0, 0);
        drive(0, 1, GRANT_M1,   0, 0);
        drive(0, 0, GRANT_NONE, 0, 0);
        // Grant M0, then assert reset mid-grant
        drive(1, 0, GRANT_M0,   0, 0);
        drain();

        @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_reset_grant",    int'(grant),    0);
        chk("async_reset_m0_grant", int'(m0_grant), 0);
        chk("async_reset_hold_cnt", int'(hold_cnt), 0);
        m0_req = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;

        rand_on = 1'b1;
        repeat (2000) begin
            @(negedge clk);
            m0_req = ($urandom_range(0, 3) != 0);
            m1_req = ($urandom_range(0, 3) != 0);
        end
        @(negedge clk);
        rand_on = 1'b0;
        m0_req  = 1'b0;
        m1_req  = 1'b0;
        repeat (2) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
